// File: rtl/ppwa_axi4_slave_regs_if.sv
// AXI4 (full) bus bundle between the ppwa master VIP and the register-bank slave.
interface ppwa_axi4_slave_regs_if #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 7
);
    logic [ID_WIDTH-1:0]   AWID;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [31:0]           WDATA;
    logic [3:0]            WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;
    logic [ID_WIDTH-1:0]   BID;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ID_WIDTH-1:0]   ARID;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic [1:0]            ARBURST;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [ID_WIDTH-1:0]   RID;
    logic [31:0]           RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
        output WDATA, WSTRB, WLAST, WVALID, input WREADY,
        input  BID, BRESP, BVALID, output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
        output BID, BRESP, BVALID, input BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
    );
endinterface

// File: rtl/ppwa_axi4_slave_regs.sv
// AXI4 burst-capable register bank: NUM_RW config words plus read-only
// period/high-time measurement words, independent write and read FSMs.
module ppwa_axi4_slave_regs #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 7,
    parameter int NUM_RW     = 8,
    parameter int NUM_CH     = 4
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    ppwa_axi4_slave_regs_if.slave   s_axi,
    output logic [32*NUM_RW-1:0]    cfg_regs,
    input  logic [64*NUM_CH-1:0]    meas_in
);
    localparam int NUM_WORDS = NUM_RW + 2 * NUM_CH;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    logic [31:0]           r_cfg [NUM_RW];
    logic                  r_live;
    w_state_t              r_w_state, w_w_state_nxt;
    r_state_t              r_r_state, w_r_state_nxt;
    logic [ADDR_WIDTH-1:0] r_w_addr, r_r_addr;
    logic [7:0]            r_w_len, r_r_len, r_w_cnt, r_r_cnt;
    logic [1:0]            r_w_burst, r_r_burst;
    logic [ID_WIDTH-1:0]   r_w_id, r_r_id;
    logic                  r_w_berr, r_w_err, r_r_berr;
    logic [31:0]           r_rdata;
    logic [1:0]            r_rresp;
    logic                  r_rlast;
    logic                  w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
    logic                  w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
    logic                  w_w_last_cnt, w_w_end, w_w_drop;
    int                    w_w_idx;
    logic [33:0]           w_ar_beat, w_r_nxt_beat;
    logic [ADDR_WIDTH-1:0] w_r_nxt_addr;

    // Illegal transfer size, or WRAP with an unsupported length, poisons the whole burst.
    function automatic logic burst_bad(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [7:0] len);
        logic len_ok;
        len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size != 3'd2) || ((burst == 2'b10) && !len_ok);
    endfunction

    // Address of the following beat for FIXED / INCR / WRAP bursts.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [7:0] len,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        inc  = a + ADDR_WIDTH'(4);
        mask = ADDR_WIDTH'({len[3:0], 2'b11});
        case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | (inc & mask);
            default: return inc;
        endcase
    endfunction

    // {RRESP, RDATA} for one read beat; measurements are sampled live here.
    function automatic logic [33:0] rd_beat(input logic [ADDR_WIDTH-1:0] a, input logic berr);
        int          idx;
        logic [31:0] d;
        idx = int'(a[ADDR_WIDTH-1:2]);
        d   = 32'h0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (idx == i) d = r_cfg[i];
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == NUM_RW + 2 * i)     d = meas_in[64*i +: 32];
            if (idx == NUM_RW + 2 * i + 1) d = meas_in[64*i+32 +: 32];
        end
        if (berr || (idx >= NUM_WORDS)) return {2'b10, 32'h0};
        else                            return {2'b00, d};
    endfunction

    assign w_aw_hs      = s_axi.AWVALID && w_awready;
    assign w_w_hs       = s_axi.WVALID && w_wready;
    assign w_ar_hs      = s_axi.ARVALID && w_arready;
    assign w_r_hs       = s_axi.RREADY && w_rvalid;
    assign w_w_idx      = int'(r_w_addr[ADDR_WIDTH-1:2]);
    assign w_w_last_cnt = (r_w_cnt == r_w_len);
    assign w_w_end      = s_axi.WLAST || w_w_last_cnt;
    assign w_w_drop     = r_w_berr || (w_w_idx >= NUM_RW);
    assign w_ar_beat    = rd_beat(s_axi.ARADDR, burst_bad(s_axi.ARSIZE, s_axi.ARBURST, s_axi.ARLEN));
    assign w_r_nxt_addr = next_addr(r_r_addr, r_r_len, r_r_burst);
    assign w_r_nxt_beat = rd_beat(w_r_nxt_addr, r_r_berr);

    // Keeps address-channel READYs low during the reset cycle itself.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) r_live <= 1'b0;
        else                r_live <= 1'b1;
    end

    // Write FSM state register.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) r_w_state <= W_IDLE;
        else                r_w_state <= w_w_state_nxt;
    end

    // Write FSM next state: address, data beats, then response.
    always_comb begin
        w_w_state_nxt = r_w_state;
        case (r_w_state)
            W_IDLE:  if (w_aw_hs) w_w_state_nxt = W_DATA; else w_w_state_nxt = W_IDLE;
            W_DATA:  if (w_w_hs && w_w_end) w_w_state_nxt = W_RESP; else w_w_state_nxt = W_DATA;
            W_RESP:  if (s_axi.BREADY) w_w_state_nxt = W_IDLE; else w_w_state_nxt = W_RESP;
            default: w_w_state_nxt = W_IDLE;
        endcase
    end

    // Write FSM outputs decoded from the state register.
    always_comb begin
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
        case (r_w_state)
            W_IDLE:  w_awready = r_live;
            W_DATA:  w_wready  = 1'b1;
            W_RESP:  w_bvalid  = 1'b1;
            default: w_awready = 1'b0;
        endcase
    end

    // Write datapath: latch AW fields, apply strobed writes, track errors.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < NUM_RW; i++) r_cfg[i] <= 32'h0;
            r_w_addr  <= '0;
            r_w_len   <= 8'd0;
            r_w_cnt   <= 8'd0;
            r_w_burst <= 2'b00;
            r_w_id    <= '0;
            r_w_berr  <= 1'b0;
            r_w_err   <= 1'b0;
        end else begin
            case (r_w_state)
                W_IDLE: if (w_aw_hs) begin
                    r_w_addr  <= s_axi.AWADDR;
                    r_w_len   <= s_axi.AWLEN;
                    r_w_burst <= s_axi.AWBURST;
                    r_w_id    <= s_axi.AWID;
                    r_w_cnt   <= 8'd0;
                    r_w_err   <= 1'b0;
                    r_w_berr  <= burst_bad(s_axi.AWSIZE, s_axi.AWBURST, s_axi.AWLEN);
                end
                W_DATA: if (w_w_hs) begin
                    for (int i = 0; i < NUM_RW; i++) begin
                        for (int b = 0; b < 4; b++) begin
                            if (!w_w_drop && (w_w_idx == i) && s_axi.WSTRB[b])
                                r_cfg[i][8*b +: 8] <= s_axi.WDATA[8*b +: 8];
                        end
                    end
                    if (w_w_drop || (s_axi.WLAST != w_w_last_cnt)) r_w_err <= 1'b1;
                    r_w_addr <= next_addr(r_w_addr, r_w_len, r_w_burst);
                    r_w_cnt  <= r_w_cnt + 8'd1;
                end
                default: r_w_cnt <= r_w_cnt;
            endcase
        end
    end

    // Read FSM state register.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) r_r_state <= R_IDLE;
        else                r_r_state <= w_r_state_nxt;
    end

    // Read FSM next state: return to idle after the last beat is taken.
    always_comb begin
        w_r_state_nxt = r_r_state;
        case (r_r_state)
            R_IDLE:  if (w_ar_hs) w_r_state_nxt = R_DATA; else w_r_state_nxt = R_IDLE;
            R_DATA:  if (w_r_hs && r_rlast) w_r_state_nxt = R_IDLE; else w_r_state_nxt = R_DATA;
            default: w_r_state_nxt = R_IDLE;
        endcase
    end

    // Read FSM outputs decoded from the state register.
    always_comb begin
        w_arready = 1'b0;
        w_rvalid  = 1'b0;
        case (r_r_state)
            R_IDLE:  w_arready = r_live;
            R_DATA:  w_rvalid  = 1'b1;
            default: w_arready = 1'b0;
        endcase
    end

    // Read datapath: beat data is registered so it holds under back-pressure
    // and a same-cycle write to the word is seen only by later beats.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_r_addr  <= '0;
            r_r_len   <= 8'd0;
            r_r_cnt   <= 8'd0;
            r_r_burst <= 2'b00;
            r_r_id    <= '0;
            r_r_berr  <= 1'b0;
            r_rdata   <= 32'h0;
            r_rresp   <= 2'b00;
            r_rlast   <= 1'b0;
        end else begin
            case (r_r_state)
                R_IDLE: if (w_ar_hs) begin
                    r_r_addr  <= s_axi.ARADDR;
                    r_r_len   <= s_axi.ARLEN;
                    r_r_burst <= s_axi.ARBURST;
                    r_r_id    <= s_axi.ARID;
                    r_r_cnt   <= 8'd0;
                    r_r_berr  <= burst_bad(s_axi.ARSIZE, s_axi.ARBURST, s_axi.ARLEN);
                    r_rdata   <= w_ar_beat[31:0];
                    r_rresp   <= w_ar_beat[33:32];
                    r_rlast   <= (s_axi.ARLEN == 8'd0);
                end
                R_DATA: if (w_r_hs) begin
                    if (r_rlast) begin
                        r_rlast <= 1'b0;
                    end else begin
                        r_r_addr <= w_r_nxt_addr;
                        r_r_cnt  <= r_r_cnt + 8'd1;
                        r_rdata  <= w_r_nxt_beat[31:0];
                        r_rresp  <= w_r_nxt_beat[33:32];
                        r_rlast  <= ((r_r_cnt + 8'd1) == r_r_len);
                    end
                end
                default: r_rlast <= r_rlast;
            endcase
        end
    end

    assign s_axi.AWREADY = w_awready;
    assign s_axi.WREADY  = w_wready;
    assign s_axi.BVALID  = w_bvalid;
    assign s_axi.BID     = r_w_id;
    assign s_axi.BRESP   = {(r_w_err || r_w_berr), 1'b0};
    assign s_axi.ARREADY = w_arready;
    assign s_axi.RVALID  = w_rvalid;
    assign s_axi.RID     = r_r_id;
    assign s_axi.RDATA   = r_rdata;
    assign s_axi.RRESP   = r_rresp;
    assign s_axi.RLAST   = r_rlast;

    for (genvar g = 0; g < NUM_RW; g++) begin : g_cfg
        assign cfg_regs[32*g +: 32] = r_cfg[g];
    end
endmodule

// File: tb/tb_ppwa_axi4_slave_regs.sv
// Directed bench for the AXI4 register bank: bursts, strobes, wrap order,
// measurement words, error responses, back-pressure and mid-burst reset.
module tb_ppwa_axi4_slave_regs;
    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [255:0] cfg_regs;
    logic [255:0] meas_in = '0;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] wr_data  [16];
    logic [31:0] exp_data [16];
    logic [1:0]  exp_resp [16];
    logic [1:0]  b_resp;
    logic [0:0]  b_id;

    ppwa_axi4_slave_regs_if #(.ID_WIDTH(1), .ADDR_WIDTH(7)) bus ();

    ppwa_axi4_slave_regs #(.ID_WIDTH(1), .ADDR_WIDTH(7), .NUM_RW(8), .NUM_CH(4)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rstn),
        .s_axi         (bus),
        .cfg_regs      (cfg_regs),
        .meas_in       (meas_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [6:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [3:0] strb, input logic [0:0] id,
                            input int bdelay);
        int t;
        @(negedge clk);
        bus.AWADDR = addr; bus.AWLEN = len; bus.AWBURST = burst; bus.AWSIZE = size;
        bus.AWID = id; bus.AWVALID = 1'b1;
        t = 0;
        while (bus.AWREADY !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        check("aw_wait", 32'(t >= 50), 32'd0);
        @(negedge clk);
        bus.AWVALID = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            bus.WDATA = wr_data[b]; bus.WSTRB = strb; bus.WLAST = (b == int'(len));
            bus.WVALID = 1'b1;
            t = 0;
            while (bus.WREADY !== 1'b1 && t < 50) begin @(negedge clk); t++; end
            check("w_wait", 32'(t >= 50), 32'd0);
            @(negedge clk);
        end
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        t = 0;
        while (bus.BVALID !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        check("b_wait", 32'(t >= 50), 32'd0);
        b_resp = bus.BRESP; b_id = bus.BID;
        for (int d = 0; d < bdelay; d++) begin
            @(negedge clk);
            check("bvalid_hold", 32'(bus.BVALID), 32'd1);
            check("bresp_hold", 32'(bus.BRESP), 32'(b_resp));
        end
        bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;
        check("bvalid_drop", 32'(bus.BVALID), 32'd0);
    endtask

    task automatic do_read(input logic [6:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input int stall_beat);
        int t;
        @(negedge clk);
        bus.ARADDR = addr; bus.ARLEN = len; bus.ARBURST = burst; bus.ARSIZE = size;
        bus.ARID = 1'b0; bus.ARVALID = 1'b1;
        t = 0;
        while (bus.ARREADY !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        check("ar_wait", 32'(t >= 50), 32'd0);
        @(negedge clk);
        bus.ARVALID = 1'b0;
        bus.RREADY  = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            t = 0;
            while (bus.RVALID !== 1'b1 && t < 50) begin @(negedge clk); t++; end
            check("r_wait", 32'(t >= 50), 32'd0);
            if (b == stall_beat) begin
                bus.RREADY = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    check("stall_rvalid", 32'(bus.RVALID), 32'd1);
                    check("stall_rdata", bus.RDATA, exp_data[b]);
                    check("stall_rlast", 32'(bus.RLAST), 32'(b == int'(len)));
                end
                bus.RREADY = 1'b1;
            end
            check($sformatf("rdata[%0d]", b), bus.RDATA, exp_data[b]);
            check($sformatf("rresp[%0d]", b), 32'(bus.RRESP), 32'(exp_resp[b]));
            check($sformatf("rlast[%0d]", b), 32'(bus.RLAST), 32'(b == int'(len)));
            @(negedge clk);
        end
        bus.RREADY = 1'b0;
        check("rvalid_drop", 32'(bus.RVALID), 32'd0);
    endtask

    initial begin
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0; bus.WLAST = 1'b0; bus.WDATA = 32'h0; bus.WSTRB = 4'h0;
        bus.AWID = 1'b0; bus.AWADDR = 7'h0; bus.AWLEN = 8'd0; bus.AWSIZE = 3'd2; bus.AWBURST = 2'b01;
        bus.ARID = 1'b0; bus.ARADDR = 7'h0; bus.ARLEN = 8'd0; bus.ARSIZE = 3'd2; bus.ARBURST = 2'b01;
        for (int i = 0; i < 16; i++) begin wr_data[i] = 32'h0; exp_data[i] = 32'h0; exp_resp[i] = 2'b00; end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(bus.AWREADY), 32'd0);
        check("rst_arready", 32'(bus.ARREADY), 32'd0);
        check("rst_wready", 32'(bus.WREADY), 32'd0);
        check("rst_bvalid", 32'(bus.BVALID), 32'd0);
        check("rst_rvalid", 32'(bus.RVALID), 32'd0);
        check("rst_rlast", 32'(bus.RLAST), 32'd0);
        check("rst_rdata", bus.RDATA, 32'd0);
        check("rst_cfg_lo", cfg_regs[31:0], 32'd0);
        check("rst_cfg_hi", cfg_regs[255:224], 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_awready", 32'(bus.AWREADY), 32'd1);
        check("post_rst_arready", 32'(bus.ARREADY), 32'd1);

        // INCR write len 7, data 1..8, then read back
        for (int i = 0; i < 8; i++) wr_data[i] = 32'(i + 1);
        do_write(7'h00, 8'd7, 2'b01, 3'd2, 4'hF, 1'b1, 0);
        check("t1_bresp", 32'(b_resp), 32'd0);
        check("t1_bid", 32'(b_id), 32'd1);
        for (int i = 0; i < 8; i++) begin exp_data[i] = 32'(i + 1); exp_resp[i] = 2'b00; end
        do_read(7'h00, 8'd7, 2'b01, 3'd2, -1);
        check("t1_cfg_w3", cfg_regs[3*32 +: 32], 32'd4);

        // WRAP len 3 from 0x08: order 0x08,0x0C,0x00,0x04
        exp_data[0] = 32'd3; exp_data[1] = 32'd4; exp_data[2] = 32'd1; exp_data[3] = 32'd2;
        do_read(7'h08, 8'd3, 2'b10, 3'd2, -1);

        // Byte strobes on word 2
        wr_data[0] = 32'hFFFF_FFFF;
        do_write(7'h08, 8'd0, 2'b01, 3'd2, 4'hF, 1'b0, 0);
        check("t3_bresp_a", 32'(b_resp), 32'd0);
        wr_data[0] = 32'h00AB_0000;
        do_write(7'h08, 8'd0, 2'b01, 3'd2, 4'b0100, 1'b0, 0);
        check("t3_bresp_b", 32'(b_resp), 32'd0);
        exp_data[0] = 32'hFFAB_FFFF;
        do_read(7'h08, 8'd0, 2'b01, 3'd2, -1);

        // Measurement words for channel 1: period 0x64, high 0x10
        meas_in[127:64] = {32'h0000_0010, 32'h0000_0064};
        exp_data[0] = 32'h64; exp_data[1] = 32'h10;
        do_read(7'h28, 8'd1, 2'b01, 3'd2, -1);
        wr_data[0] = 32'hDEAD_BEEF;
        do_write(7'h28, 8'd0, 2'b01, 3'd2, 4'hF, 1'b0, 0);
        check("t4_ro_bresp", 32'(b_resp), 32'd2);
        exp_data[0] = 32'h64;
        do_read(7'h28, 8'd0, 2'b01, 3'd2, -1);

        // Out-of-range word
        exp_data[0] = 32'h0; exp_resp[0] = 2'b10;
        do_read(7'h40, 8'd0, 2'b01, 3'd2, -1);

        // Size error write (dropped), WRAP bad-length read (all SLVERR, data 0)
        wr_data[0] = 32'h99;
        do_write(7'h10, 8'd0, 2'b01, 3'd1, 4'hF, 1'b0, 0);
        check("t6_size_bresp", 32'(b_resp), 32'd2);
        check("t6_size_cfg_w4", cfg_regs[4*32 +: 32], 32'd5);
        for (int i = 0; i < 3; i++) begin exp_data[i] = 32'h0; exp_resp[i] = 2'b10; end
        do_read(7'h00, 8'd2, 2'b10, 3'd2, -1);

        // FIXED write len 2 to word 6: last beat wins
        wr_data[0] = 32'h61; wr_data[1] = 32'h62; wr_data[2] = 32'h63;
        do_write(7'h18, 8'd2, 2'b00, 3'd2, 4'hF, 1'b0, 0);
        check("t7_fixed_bresp", 32'(b_resp), 32'd0);
        check("t7_fixed_w6", cfg_regs[6*32 +: 32], 32'h63);
        check("t7_fixed_w7", cfg_regs[7*32 +: 32], 32'd8);

        // RREADY low 3 cycles at beat 3 of an 8-beat read
        exp_data[0] = 32'd1; exp_data[1] = 32'd2; exp_data[2] = 32'hFFAB_FFFF; exp_data[3] = 32'd4;
        exp_data[4] = 32'd5; exp_data[5] = 32'd6; exp_data[6] = 32'h63; exp_data[7] = 32'd8;
        for (int i = 0; i < 8; i++) exp_resp[i] = 2'b00;
        do_read(7'h00, 8'd7, 2'b01, 3'd2, 3);

        // BREADY held off 5 cycles
        wr_data[0] = 32'h55;
        do_write(7'h14, 8'd0, 2'b01, 3'd2, 4'hF, 1'b1, 5);
        check("t9_bresp", 32'(b_resp), 32'd0);
        check("t9_cfg_w5", cfg_regs[5*32 +: 32], 32'h55);

        // Reset during beat 4 of an 8-beat write
        @(negedge clk);
        bus.AWADDR = 7'h00; bus.AWLEN = 8'd7; bus.AWBURST = 2'b01; bus.AWSIZE = 3'd2; bus.AWVALID = 1'b1;
        check("t10_awready", 32'(bus.AWREADY), 32'd1);
        @(negedge clk);
        bus.AWVALID = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bus.WDATA = 32'hA0 + 32'(b); bus.WSTRB = 4'hF; bus.WLAST = 1'b0; bus.WVALID = 1'b1;
            check("t10_wready", 32'(bus.WREADY), 32'd1);
            @(negedge clk);
        end
        check("t10_pre_w3", cfg_regs[3*32 +: 32], 32'hA3);
        bus.WDATA = 32'hA4;
        rstn = 1'b0;
        @(negedge clk);
        bus.WVALID = 1'b0;
        check("t10_rst_awready", 32'(bus.AWREADY), 32'd0);
        check("t10_rst_wready", 32'(bus.WREADY), 32'd0);
        check("t10_rst_bvalid", 32'(bus.BVALID), 32'd0);
        check("t10_rst_rvalid", 32'(bus.RVALID), 32'd0);
        check("t10_rst_w0", cfg_regs[31:0], 32'd0);
        check("t10_rst_w3", cfg_regs[3*32 +: 32], 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("t10_post_awready", 32'(bus.AWREADY), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t10_no_bvalid", 32'(bus.BVALID), 32'd0);
        end

        // Recovery after reset
        wr_data[0] = 32'h1234;
        do_write(7'h00, 8'd0, 2'b01, 3'd2, 4'hF, 1'b0, 0);
        check("t11_bresp", 32'(b_resp), 32'd0);
        exp_data[0] = 32'h1234; exp_resp[0] = 2'b00;
        do_read(7'h00, 8'd0, 2'b01, 3'd2, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
